// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared LSU opcodes, size codes, LR/SC selects and state types
package riscv_lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_AMO   = 7'b0101111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] F5_LR = 5'b00010;
  localparam logic [4:0] F5_SC = 5'b00011;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} lsu_state_e;
  typedef enum logic [1:0] {K_LOAD, K_STORE, K_LR, K_SC} lsu_kind_e;

  function automatic logic lsu_legal(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] f5);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD:  ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      OP_STORE: ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      OP_AMO:   ok = (f3 == F3_W) && ((f5 == F5_LR) || (f5 == F5_SC));
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic lsu_kind_e lsu_kind(input logic [6:0] op, input logic [4:0] f5);
    lsu_kind_e k;
    if (op == OP_STORE) k = K_STORE;
    else if (op == OP_AMO) k = (f5 == F5_SC) ? K_SC : K_LR;
    else k = K_LOAD;
    return k;
  endfunction

  function automatic logic lsu_is_read(input lsu_kind_e k);
    return (k == K_LOAD) || (k == K_LR);
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// rtl/lsu_store_align.sv - byte enables, lane-replicated store data and alignment check
module lsu_store_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misaligned
);

  // funct3[1:0] is the access size for both signed and unsigned loads and for stores
  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      2'b10: begin
        be         = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store unit with LR/SC reservation
module lsu_mem_ctrl
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [4:0]        funct5,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] drdata,
  output logic              misaligned,
  output logic              illegal
);

  lsu_state_e          state_q, state_d;
  lsu_kind_e           kind_in, kind_q;
  logic                legal_in, mis_in, accept, is_write_in;
  logic                resv_hit_in, resv_hit_q;
  logic [3:0]          be_in, we_q;
  logic [DATA_W-1:0]   lane_in, wdata_q, drdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mis_q, ill_q;
  logic                resv_valid_q;
  logic [ADDR_W-1:2]   resv_addr_q;

  lsu_store_align u_align (
    .funct3     (funct3),
    .addr       (addr[1:0]),
    .wdata      (wdata),
    .be         (be_in),
    .wdata_lane (lane_in),
    .misaligned (mis_in)
  );

  assign legal_in    = lsu_legal(op, funct3, funct5);
  assign kind_in     = lsu_kind(op, funct5);
  assign is_write_in = (kind_in == K_STORE) || (kind_in == K_SC);
  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign resv_hit_in = resv_valid_q && (resv_addr_q == addr[ADDR_W-1:2]);
  assign resv_hit_q  = resv_valid_q && (resv_addr_q == addr_q[ADDR_W-1:2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!legal_in || mis_in)                  state_d = ST_RESP;
          else if (kind_in == K_SC && !resv_hit_in) state_d = ST_RESP;
          else                                      state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = lsu_is_read(kind_q) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (mem_rvalid) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      kind_q       <= K_LOAD;
      we_q         <= 4'b0000;
      wdata_q      <= '0;
      drdata_q     <= '0;
      mis_q        <= 1'b0;
      ill_q        <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        kind_q   <= kind_in;
        ill_q    <= ~legal_in;
        mis_q    <= legal_in & mis_in;
        we_q     <= is_write_in ? be_in : 4'b0000;
        wdata_q  <= is_write_in ? lane_in : '0;
        drdata_q <= '0;
        // Every SC consumes the reservation; the fail flag is known at accept time
        if (legal_in && kind_in == K_SC) begin
          resv_valid_q <= 1'b0;
          drdata_q     <= {{(DATA_W-1){1'b0}}, ~resv_hit_in | mis_in};
        end
      end
      if (state_q == ST_REQ && mem_ready && kind_q == K_STORE && resv_hit_q)
        resv_valid_q <= 1'b0;
      if (state_q == ST_WAIT && mem_rvalid) begin
        drdata_q <= mem_rdata;
        if (kind_q == K_LR) begin
          resv_valid_q <= 1'b1;
          resv_addr_q  <= addr_q[ADDR_W-1:2];
        end
      end
    end
  end

  assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_we     = mem_valid ? we_q : 4'b0000;
  assign mem_wdata  = mem_valid ? wdata_q : '0;
  assign daddr      = resp_valid ? addr_q : '0;
  assign drdata     = resp_valid ? drdata_q : '0;
  assign misaligned = resp_valid & mis_q;
  assign illegal    = resp_valid & ill_q;

endmodule
